// File: rtl/da_tx_pkg.sv
// Shared types and constants for the I2S / left-justified DAC transmitter.
package da_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tx_state_t;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;

  // Serial bit for slot position k of an MSB-aligned 32-bit word.
  // In I2S mode everything slips one BCK later, so position 0 is always 0.
  function automatic logic slot_bit(input logic [SLOT_BITS-1:0] word,
                                    input logic [4:0]           k,
                                    input logic                 i2s);
    logic [4:0] idx;
    idx = i2s ? (5'd0 - k) : (5'd31 - k);
    slot_bit = (i2s && (k == 5'd0)) ? 1'b0 : word[idx];
  endfunction

endpackage

// File: rtl/da_bclk_gen.sv
// Bit-clock generator: divides fpga_gclk into BCK and counts bits within a frame.
module da_bclk_gen #(
  parameter int BCK_DIV = 4
) (
  input  logic       fpga_gclk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       clear,
  output logic       bck,
  output logic       bck_fall,
  output logic [5:0] bit_cnt
);

  logic [7:0] div_cnt;
  logic       div_wrap;

  assign div_wrap = (div_cnt == 8'(BCK_DIV - 1));
  assign bck_fall = run && !clear && div_wrap && bck;

  // Divider wraps every BCK_DIV cycles and toggles BCK; each falling BCK advances the bit counter.
  always_ff @(posedge fpga_gclk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bck     <= 1'b0;
      bit_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
      bck     <= 1'b0;
      bit_cnt <= '0;
    end else if (run) begin
      if (div_wrap) begin
        div_cnt <= '0;
        bck     <= ~bck;
        if (bck) begin
          bit_cnt <= bit_cnt + 6'd1;
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/da_i2s_tx.sv
// Stereo serial audio transmitter (I2S or left-justified) with a one-pair holding register.
module da_i2s_tx
  import da_tx_pkg::*;
#(
  parameter int BCK_DIV   = 4,
  parameter int DATA_BITS = 24
) (
  input  logic                 fpga_gclk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 fmt_i2s,
  input  logic [DATA_BITS-1:0] sample_l,
  input  logic [DATA_BITS-1:0] sample_r,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 BCK,
  output logic                 LRCK,
  output logic                 SDATA,
  output logic                 frame_start,
  output logic                 underrun
);

  tx_state_t state_q, state_d;

  logic                 fmt_q, fmt_eff;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_l, hold_r;
  logic [DATA_BITS-1:0] frame_l, frame_r;
  logic [DATA_BITS-1:0] load_l, load_r, src_word;
  logic [SLOT_BITS-1:0] src_aligned;
  logic [5:0]           bit_cnt, next_bit;
  logic                 bck_fall;
  logic                 entry, load, frame_end, accept;
  logic                 sdata_q, sdata_d;
  logic                 frame_start_q, underrun_q;

  da_bclk_gen #(.BCK_DIV(BCK_DIV)) u_bclk_gen (
    .fpga_gclk (fpga_gclk),
    .reset_n   (reset_n),
    .run       (state_q != IDLE),
    .clear     (state_q == IDLE),
    .bck       (BCK),
    .bck_fall  (bck_fall),
    .bit_cnt   (bit_cnt)
  );

  assign accept       = sample_valid && !hold_full;
  assign load_l       = hold_full ? hold_l : '0;
  assign load_r       = hold_full ? hold_r : '0;
  assign fmt_eff      = (state_q == IDLE) ? fmt_i2s : fmt_q;
  assign sample_ready = !hold_full;
  assign LRCK         = bit_cnt[5];
  assign SDATA        = sdata_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

  // State register.
  always_ff @(posedge fpga_gclk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state plus the frame-load / frame-end strobes.
  always_comb begin
    state_d   = state_q;
    entry     = 1'b0;
    load      = 1'b0;
    frame_end = bck_fall && (bit_cnt == 6'(FRAME_BITS - 1));
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          entry   = 1'b1;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (!enable)   state_d = DRAIN;
        if (frame_end) load    = 1'b1;
      end
      DRAIN: begin
        if (frame_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next serial bit: on a load it is slot bit 0 of the freshly loaded left word.
  always_comb begin
    next_bit    = load ? 6'd0 : bit_cnt + 6'd1;
    src_word    = load ? load_l : (next_bit[5] ? frame_r : frame_l);
    src_aligned = {src_word, {(SLOT_BITS - DATA_BITS){1'b0}}};
    sdata_d     = sdata_q;
    if (load)
      sdata_d = slot_bit(src_aligned, next_bit[4:0], fmt_eff);
    else if (state_q == IDLE || (state_q == DRAIN && frame_end))
      sdata_d = 1'b0;
    else if (bck_fall)
      sdata_d = slot_bit(src_aligned, next_bit[4:0], fmt_eff);
  end

  // Datapath registers: holding register, frame words, serial output and status flags.
  always_ff @(posedge fpga_gclk or negedge reset_n) begin
    if (!reset_n) begin
      fmt_q         <= 1'b0;
      hold_full     <= 1'b0;
      hold_l        <= '0;
      hold_r        <= '0;
      frame_l       <= '0;
      frame_r       <= '0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      if (state_q == IDLE) fmt_q <= fmt_i2s;
      if (accept) begin
        hold_full <= 1'b1;
        hold_l    <= sample_l;
        hold_r    <= sample_r;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (load) begin
        frame_l <= load_l;
        frame_r <= load_r;
      end
      sdata_q       <= sdata_d;
      frame_start_q <= load;
      underrun_q    <= (underrun_q && !entry) || (load && !hold_full);
    end
  end

endmodule
